// File: rtl/tlu_pkg.sv
// Shared types and constants for the DUT-side TLU trigger handshake.
package tlu_pkg;

  // Handshake sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    SHIFT = 3'd2,
    STORE = 3'd3,
    ERROR = 3'd4
  } tlu_state_e;

  // Readout word layout: bit 31 marks a trigger word, bit 30 flags a
  // handshake that timed out, the low 16 bits carry the trigger ID.
  localparam int unsigned TRIG_WORD_MARKER = 31;
  localparam int unsigned ERR_BIT          = 30;
  localparam int unsigned ID_W             = 16;
  localparam int unsigned ID_IDX_W         = $clog2(ID_W);

  localparam logic [31:0] ERR_WORD = (32'h1 << TRIG_WORD_MARKER) | (32'h1 << ERR_BIT);

  // Build a good trigger word from a captured ID.
  function automatic logic [31:0] trig_word(input logic [ID_W-1:0] id);
    logic [31:0] w;
    w = 32'(id);
    w[TRIG_WORD_MARKER] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/tlu_sync_edge.sv
// Two-flop synchronizer for an asynchronous TLU line plus a rising-edge
// detector on the synchronized level. Generic enough for TLU_RESET as well.
module tlu_sync_edge
  import tlu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q, dly_d;

  // Next values: shift the line through the synchronizer and delay stage.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Synchronizer and edge-detect registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~dly_q;

endmodule

// File: rtl/tlu_dut_handshake.sv
// DUT-side TLU responder: answers a TLU trigger with BUSY, clocks the
// trigger number out of the TLU serially on TLU_CLOCK and hands each
// result to readout as one 32-bit word.
//
// Output stream: DATA_OUT is meaningful only while DATA_VALID is high;
// a word transfers on every rising CLK40 edge where DATA_VALID and
// DATA_READY are both high, after which DATA_VALID drops. While waiting,
// DATA_VALID and DATA_OUT hold. The single-word slot is never overwritten
// because a new handshake only starts while the slot is empty.
module tlu_dut_handshake
  import tlu_pkg::*;
#(
  parameter int unsigned TRIG_BITS = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        CLK40,
  input  logic        RESETB,
  input  logic        ENABLE,
  input  logic        VETO,
  input  logic        TLU_TRIGGER,
  output logic        TLU_BUSY,
  output logic        TLU_CLOCK,
  output logic [31:0] DATA_OUT,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic [31:0] TRIG_COUNT,
  output logic [7:0]  ERR_COUNT,
  output logic [2:0]  dbg_state
);

  localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W = (TRIG_BITS > 1) ? $clog2(TRIG_BITS) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [PH_W-1:0]  PH_HIGH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LOW_FIRST = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(TRIG_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT    = TMO_W'(TIMEOUT);

  tlu_state_e        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic [31:0]       trig_cnt_q, trig_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d;
  logic              tlu_clk_q, tlu_clk_d;

  logic              trig_s;
  logic              trig_rise;

  tlu_sync_edge u_trig_sync (
    .clk      (CLK40),
    .rst_n    (RESETB),
    .async_in (TLU_TRIGGER),
    .sync_out (trig_s),
    .rise     (trig_rise)
  );

  // Sequencer next state, serial capture, output slot and counters.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    tmo_d      = tmo_q;
    id_d       = id_q;
    data_d     = data_q;
    valid_d    = valid_q;
    trig_cnt_d = trig_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (valid_q && DATA_READY) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Edges that arrive while blocked are dropped, not remembered.
        if (trig_rise && ENABLE && !VETO && !valid_q) begin
          state_d = ACK;
          tmo_d   = '0;
          id_d    = '0;
        end
      end
      ACK: begin
        if (!trig_s) begin
          state_d = SHIFT;
          bit_d   = '0;
          phase_d = '0;
        end else if (tmo_q == TMO_LIMIT) begin
          state_d = ERROR;
          data_d  = ERR_WORD;
          valid_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SHIFT: begin
        // Sample late in the high phase so the TLU's data has crossed the synchronizer.
        if (phase_q == PH_HIGH_LAST) begin
          id_d[ID_IDX_W'(bit_q)] = trig_s;
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STORE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      STORE: begin
        data_d     = trig_word(id_q);
        valid_d    = 1'b1;
        trig_cnt_d = trig_cnt_q + 32'd1;
        state_d    = IDLE;
      end
      ERROR: begin
        if (!trig_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin-side outputs, registered so the RJ45 lines never glitch.
  always_comb begin
    busy_d    = (state_q != IDLE) | ~ENABLE | VETO | valid_q;
    tlu_clk_d = (state_d == SHIFT) && (phase_d < PH_LOW_FIRST);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLK40 or negedge RESETB) begin
    if (!RESETB) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      tmo_q      <= '0;
      id_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      trig_cnt_q <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
      tlu_clk_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      tmo_q      <= tmo_d;
      id_q       <= id_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      trig_cnt_q <= trig_cnt_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
      tlu_clk_q  <= tlu_clk_d;
    end
  end

  assign TLU_BUSY   = busy_q;
  assign TLU_CLOCK  = tlu_clk_q;
  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign TRIG_COUNT = trig_cnt_q;
  assign ERR_COUNT  = err_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tlu_dut_handshake.sv
// Bench for the TLU DUT handshake: a behavioural TLU master drives the
// trigger/data line, a scoreboard holds the words readout should receive.
module tb_tlu_dut_handshake;

  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned CLK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESETB = 1'b0;
  logic        ENABLE = 1'b0;
  logic        VETO = 1'b0;
  logic        TLU_TRIGGER = 1'b0;
  logic        DATA_READY = 1'b0;
  logic        TLU_BUSY, TLU_CLOCK, DATA_VALID;
  logic [31:0] DATA_OUT, TRIG_COUNT;
  logic [7:0]  ERR_COUNT;
  logic [2:0]  dbg_state;

  logic        u1_trig = 1'b0;
  logic        u1_busy, u1_clock, u1_valid;
  logic [31:0] u1_data, u1_tcnt;
  logic [7:0]  u1_ecnt;
  logic [2:0]  u1_dbg;

  tlu_dut_handshake #(.TRIG_BITS(16), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .CLK40(clk), .RESETB(RESETB), .ENABLE(ENABLE), .VETO(VETO),
    .TLU_TRIGGER(TLU_TRIGGER), .TLU_BUSY(TLU_BUSY), .TLU_CLOCK(TLU_CLOCK),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .TRIG_COUNT(TRIG_COUNT), .ERR_COUNT(ERR_COUNT), .dbg_state(dbg_state)
  );

  tlu_dut_handshake #(.TRIG_BITS(8), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut8 (
    .CLK40(clk), .RESETB(RESETB), .ENABLE(1'b1), .VETO(1'b0),
    .TLU_TRIGGER(u1_trig), .TLU_BUSY(u1_busy), .TLU_CLOCK(u1_clock),
    .DATA_OUT(u1_data), .DATA_VALID(u1_valid), .DATA_READY(1'b1),
    .TRIG_COUNT(u1_tcnt), .ERR_COUNT(u1_ecnt), .dbg_state(u1_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          exp_trig = 0;
  int          exp_err = 0;

  int          cyc = 0;
  logic        rdy_want = 1'b1;
  int          tlu_phase = 0;      // 0 manual, 1 waiting for BUSY, 2 serving bits
  logic [15:0] srv_id = '0;
  int          srv_bit = 0;
  int          trig_cyc = 0;
  int          busy_lat = -1;

  int          n_pulses = 0;
  int          n_words = 0;
  int          run_len = 0;
  int          hi_runs[$];
  int          lo_runs[$];
  int          last_lo = -1;
  int          valid_cyc = -1;
  int          busy_rise_cyc = -1;
  int          busy_fall_cyc = -1;
  logic        clk_prev = 1'b0, valid_prev = 1'b0, busy_prev = 1'b0, acc_prev = 1'b0;
  logic [31:0] data_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // ---------------- per-cycle driver / monitor ----------------
  task automatic tick();
    logic acc;
    logic [31:0] want;
    @(negedge clk);
    cyc++;
    DATA_READY = rdy_want;
    // TLU master: drop the trigger on BUSY, then put ID bit n on the line
    // at the n-th TLU_CLOCK rise and return it low on each fall.
    if (tlu_phase == 1) begin
      if (TLU_BUSY) begin
        TLU_TRIGGER = 1'b0;
        tlu_phase = 2;
        busy_lat = cyc - trig_cyc;
      end
    end else if (tlu_phase == 2) begin
      if (TLU_CLOCK && !clk_prev) begin
        TLU_TRIGGER = (srv_bit < 16) ? srv_id[srv_bit] : 1'b0;
        srv_bit++;
      end else if (!TLU_CLOCK && clk_prev) begin
        TLU_TRIGGER = 1'b0;
      end
    end
    if (TLU_CLOCK && !clk_prev) begin
      n_pulses++;
      if (n_pulses > 1) lo_runs.push_back(run_len);
    end
    if (!TLU_CLOCK && clk_prev) hi_runs.push_back(run_len);
    if (DATA_VALID && !valid_prev) begin
      n_words++;
      valid_cyc = cyc;
      if (n_pulses > 0 && !TLU_CLOCK) last_lo = run_len;
    end
    if (TLU_BUSY && !busy_prev) busy_rise_cyc = cyc;
    if (!TLU_BUSY && busy_prev) busy_fall_cyc = cyc;
    if (valid_prev && !acc_prev && DATA_VALID) check("data_stable", DATA_OUT, data_prev);
    acc = DATA_VALID && DATA_READY;
    if (acc) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      check("sb_word", DATA_OUT, want);
    end
    if (TLU_CLOCK == clk_prev) run_len++;
    else run_len = 1;
    acc_prev = acc;
    data_prev = DATA_OUT;
    valid_prev = DATA_VALID;
    clk_prev = TLU_CLOCK;
    busy_prev = TLU_BUSY;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(TLU_BUSY), 0);
    check({tag, "_clock"}, 32'(TLU_CLOCK), 0);
    check({tag, "_data"}, DATA_OUT, 0);
    check({tag, "_valid"}, 32'(DATA_VALID), 0);
    check({tag, "_tcnt"}, TRIG_COUNT, 0);
    check({tag, "_ecnt"}, 32'(ERR_COUNT), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(tlu_pkg::IDLE));
  endtask

  task automatic wait_busy_low(input string tag);
    for (int i = 0; i < 40 && TLU_BUSY; i++) tick();
    check(tag, 32'(TLU_BUSY), 0);
  endtask

  // One TLU handshake on the 16-bit unit. abort_at/en_drop_at give a pulse
  // number at which RESETB is pulsed or ENABLE is dropped (0 = never).
  task automatic hs0(input logic [15:0] id, input int abort_at, input int en_drop_at);
    bit done;
    int start;
    n_pulses = 0;
    hi_runs.delete();
    lo_runs.delete();
    last_lo = -1;
    srv_id = id;
    srv_bit = 0;
    start = n_words;
    busy_lat = -1;
    TLU_TRIGGER = 1'b1;
    trig_cyc = cyc;
    tlu_phase = 1;
    done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      tick();
      if (en_drop_at > 0 && n_pulses == en_drop_at) ENABLE = 1'b0;
      if (abort_at > 0 && n_pulses == abort_at) begin
        RESETB = 1'b0;
        #1;
        check_reset_outputs("abort");
        tlu_phase = 0;
        TLU_TRIGGER = 1'b0;
        exp_trig = 0;
        exp_err = 0;
        tick();
        RESETB = 1'b1;
        done = 1'b1;
      end
      if (n_words != start) done = 1'b1;
    end
    tlu_phase = 0;
    check("hs_finished", 32'(done), 1);
  endtask

  task automatic check_pulses(input string tag, input int nbits);
    check({tag, "_pulses"}, n_pulses, nbits);
    check({tag, "_hi_n"}, hi_runs.size(), nbits);
    check({tag, "_lo_n"}, lo_runs.size(), nbits - 1);
    foreach (hi_runs[i]) check({tag, "_hi_len"}, hi_runs[i], CLK_DIV);
    foreach (lo_runs[i]) check({tag, "_lo_len"}, lo_runs[i], CLK_DIV);
    // last low phase plus the single store cycle before the word appears
    check({tag, "_last_lo"}, last_lo, CLK_DIV + 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w0;
    int busy_low;
    int hold;
    int u1_pulses;
    int u1_bit;
    logic u1_prev;
    logic [15:0] rid;
    logic [15:0] u1_id;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    ENABLE = 1'b1;
    RESETB = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(TLU_BUSY), 0);

    // Normal handshake, ID 0x1234
    exp_q.push_back(32'h8000_1234);
    exp_trig++;
    hs0(16'h1234, 0, 0);
    check("norm_busy_lat", busy_lat, 4);
    check_pulses("norm", 16);
    wait_busy_low("norm_idle");
    check("norm_busy_fall", busy_fall_cyc - valid_cyc, 2);
    check("norm_tcnt", TRIG_COUNT, exp_trig);
    check("norm_sb_empty", exp_q.size(), 0);

    // Timeout: trigger held high far beyond the limit
    w0 = n_words;
    n_pulses = 0;
    busy_rise_cyc = -1;
    valid_cyc = -1;
    exp_q.push_back(32'hC000_0000);
    exp_err++;
    TLU_TRIGGER = 1'b1;
    repeat (2000) tick();
    check("tmo_words", n_words - w0, 1);
    check("tmo_latency", valid_cyc - busy_rise_cyc, TIMEOUT);
    check("tmo_pulses", n_pulses, 0);
    check("tmo_ecnt", 32'(ERR_COUNT), exp_err);
    check("tmo_hold_busy", 32'(TLU_BUSY), 1);
    TLU_TRIGGER = 1'b0;
    wait_busy_low("tmo_idle");
    check("tmo_state", 32'(dbg_state), 32'(tlu_pkg::IDLE));
    check("tmo_tcnt", TRIG_COUNT, exp_trig);
    check("tmo_sb_empty", exp_q.size(), 0);

    // Back-pressure: slot full, second trigger must be ignored
    rdy_want = 1'b0;
    exp_q.push_back(32'h8000_0005);
    exp_trig++;
    hs0(16'h0005, 0, 0);
    w0 = n_words;
    n_pulses = 0;
    busy_low = 0;
    TLU_TRIGGER = 1'b1;
    repeat (20) begin tick(); if (!TLU_BUSY) busy_low++; end
    TLU_TRIGGER = 1'b0;
    repeat (20) begin tick(); if (!TLU_BUSY) busy_low++; end
    check("bp_busy_held", busy_low, 0);
    check("bp_pulses", n_pulses, 0);
    check("bp_valid", 32'(DATA_VALID), 1);
    check("bp_data", DATA_OUT, 32'h8000_0005);
    rdy_want = 1'b1;
    wait_busy_low("bp_release");
    check("bp_sb_empty", exp_q.size(), 0);
    repeat (20) tick();
    check("bp_not_queued", n_words - w0, 0);
    exp_q.push_back(32'h8000_0006);
    exp_trig++;
    hs0(16'h0006, 0, 0);
    check_pulses("bp2", 16);
    wait_busy_low("bp2_idle");
    check("bp_tcnt", TRIG_COUNT, exp_trig);

    // Gating: ENABLE low, then VETO high
    for (int g = 0; g < 2; g++) begin
      if (g == 0) ENABLE = 1'b0;
      else VETO = 1'b1;
      w0 = n_words;
      n_pulses = 0;
      repeat (3) tick();
      check("gate_busy", 32'(TLU_BUSY), 1);
      TLU_TRIGGER = 1'b1;
      repeat (30) tick();
      TLU_TRIGGER = 1'b0;
      repeat (10) tick();
      ENABLE = 1'b1;
      VETO = 1'b0;
      wait_busy_low("gate_release");
      repeat (20) tick();
      check("gate_words", n_words - w0, 0);
      check("gate_pulses", n_pulses, 0);
    end
    check("gate_tcnt", TRIG_COUNT, exp_trig);

    // ENABLE dropped mid-shift: the word still completes
    exp_q.push_back(32'h8000_BEEF);
    exp_trig++;
    hs0(16'hBEEF, 0, 3);
    check_pulses("endrop", 16);
    repeat (4) tick();
    check("endrop_busy", 32'(TLU_BUSY), 1);
    ENABLE = 1'b1;
    wait_busy_low("endrop_idle");
    check("endrop_sb_empty", exp_q.size(), 0);
    check("endrop_tcnt", TRIG_COUNT, exp_trig);

    // Reset pulsed while bit 7 is being shifted
    w0 = n_words;
    hs0(16'h3C3C, 8, 0);
    repeat (40) tick();
    check("rst_no_word", n_words - w0, 0);
    check("rst_valid", 32'(DATA_VALID), 0);
    exp_q.push_back(32'h8000_FFFF);
    exp_trig++;
    hs0(16'hFFFF, 0, 0);
    check_pulses("rst_next", 16);
    wait_busy_low("rst_next_idle");
    check("rst_next_tcnt", TRIG_COUNT, exp_trig);

    // Random IDs with random consumer stall
    for (int k = 0; k < 6; k++) begin
      rid = 16'($urandom_range(0, 65535));
      hold = $urandom_range(0, 6);
      rdy_want = (hold == 0);
      exp_q.push_back(32'h8000_0000 | 32'(rid));
      exp_trig++;
      hs0(rid, 0, 0);
      check_pulses("rand", 16);
      repeat (hold) tick();
      rdy_want = 1'b1;
      wait_busy_low("rand_idle");
      check("rand_tcnt", TRIG_COUNT, exp_trig);
    end

    // 8-bit unit: only the low 8 bits of the served ID are shifted
    u1_id = 16'h01A5;
    u1_trig = 1'b1;
    for (int i = 0; i < 50 && !u1_busy; i++) tick();
    check("u8_busy", 32'(u1_busy), 1);
    u1_trig = 1'b0;
    u1_pulses = 0;
    u1_bit = 0;
    u1_prev = 1'b0;
    for (int i = 0; i < 400 && !u1_valid; i++) begin
      tick();
      if (u1_clock && !u1_prev) begin
        u1_trig = (u1_bit < 16) ? u1_id[u1_bit] : 1'b0;
        u1_bit++;
        u1_pulses++;
      end else if (!u1_clock && u1_prev) begin
        u1_trig = 1'b0;
      end
      u1_prev = u1_clock;
    end
    check("u8_valid", 32'(u1_valid), 1);
    check("u8_data", u1_data, 32'h8000_0000 | (32'(u1_id) & 32'h0000_00FF));
    check("u8_pulses", u1_pulses, 8);
    tick();
    check("u8_tcnt", u1_tcnt, 1);
    check("u8_ecnt", 32'(u1_ecnt), 0);
    repeat (20) tick();
    check("u8_state", 32'(u1_dbg), 32'(tlu_pkg::IDLE));

    // Final totals
    repeat (10) tick();
    check("final_sb_empty", exp_q.size(), 0);
    check("final_ecnt", 32'(ERR_COUNT), exp_err);
    check("final_tcnt", TRIG_COUNT, exp_trig);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
